pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 36, width of the control bundle (a zero control bundle is a pipeline bubble/NOP).
REQ-002 Parameter DATA_W, default 256, width of the concatenated datapath payload (PC, operands, immediates, register IDs).
REQ-003 Parameter CNT_W, default 32, width of each performance counter.
REQ-004 Port Clk, input, 1, the only clock; all state updates on posedge Clk.
REQ-005 Port Rst, input, 1, synchronous active-high reset.
REQ-006 Port flush, input, 1, kill every entry held in the stage.
REQ-007 Port up_valid, input, 1, upstream offers an entry.
REQ-008 Port up_ready, output, 1, stage can accept an entry this cycle.
REQ-009 Port ctrl_in, input, CTRL_W, control bundle of the offered entry.
REQ-010 Port data_in, input, DATA_W, payload of the offered entry.
REQ-011 Port dn_valid, output, 1, output entry valid.
REQ-012 Port dn_ready, input, 1, downstream accepts the output entry (a low value is a stall).
REQ-013 Port ctrl_out, output, CTRL_W, registered control bundle.
REQ-014 Port data_out, output, DATA_W, registered payload.
REQ-015 Ports stall_cnt, flush_cnt, xfer_cnt, output, CNT_W each, performance counters (see Configuration).

Function
REQ-016 The stage SHALL hold two entries: a main register driving the outputs and one skid entry; each entry has a valid bit.
REQ-017 up_ready SHALL equal NOT skid_valid, driven directly from a register with no combinational path from dn_ready.
REQ-018 An upstream transfer SHALL occur when up_valid and up_ready are both 1; a downstream transfer SHALL occur when dn_valid and dn_ready are both 1.
REQ-019 Latency SHALL be one cycle: an entry accepted into an empty stage at edge N SHALL appear on the outputs after edge N.
REQ-020 Throughput SHALL be one entry per cycle while dn_ready is held at 1.
REQ-021 The main register SHALL load when it is empty or a downstream transfer occurs; the source SHALL be the skid entry if the skid is valid, otherwise the upstream entry if an upstream transfer occurs, otherwise the main register SHALL become invalid.
REQ-022 An upstream entry accepted while the main register is valid and no downstream transfer occurs SHALL go to the skid entry.
REQ-023 Entry order SHALL be preserved; no entry SHALL be dropped or duplicated.
REQ-024 While dn_valid is 0, ctrl_out SHALL be all zeros (bubble); data_out SHALL be the last loaded payload.
REQ-025 When flush is 1 at an edge, both valid bits SHALL clear, any upstream offer in that cycle SHALL be discarded, and no downstream transfer SHALL be counted.
REQ-026 Priority at an edge SHALL be Rst, then flush, then transfer logic.
REQ-027 ctrl_in and data_in SHALL be ignored whenever up_valid is 0.

Reset
REQ-028 When Rst is 1 at an edge, the stage SHALL set dn_valid to 0, set the skid valid bit to 0, set up_ready to 1, set ctrl_out to 0, set data_out to 0, and set all counters to 0.
REQ-029 Rst SHALL override flush and any handshake in the same cycle, and an entry in flight SHALL be lost.

Configuration
REQ-030 With macro PIPE_STAGE_PERF_EN defined, the counters SHALL be implemented as follows:
- stall_cnt SHALL count +1 per cycle with dn_valid=1 and dn_ready=0.
- flush_cnt SHALL count +1 per cycle with flush=1 and at least one valid entry.
- xfer_cnt SHALL count +1 per downstream transfer.
- Each counter SHALL saturate at all ones.
REQ-031 Without PIPE_STAGE_PERF_EN, the three counter ports SHALL remain present and SHALL be tied to constant zero, with no counter flops.

Verification
REQ-032 Apply Rst for one edge, then release with up_valid=0 -> dn_valid=0, up_ready=1, ctrl_out=0, data_out=0.
REQ-033 Stream entries A=0x1, B=0x2, C=0x3 on consecutive cycles with dn_ready=1 -> data_out shows A, B, C on the three cycles following acceptance, and xfer_cnt=3.
REQ-034 Hold dn_ready=0 while offering A, B, C -> A is in main, B is in skid, up_ready=0, and C is held upstream; after dn_ready=1 the outputs are A, B, C in order, and stall_cnt equals the number of stalled cycles.
REQ-035 Raise flush for one cycle while the main and skid entries are valid and up_valid=1 -> next cycle dn_valid=0, ctrl_out=0, up_ready=1, and flush_cnt=1.
REQ-036 Assert Rst and flush together with entries valid -> reset state is reached and flush_cnt=0.
REQ-037 With PIPE_STAGE_PERF_EN and CNT_W=4, hold the stall for 20 cycles -> stall_cnt=15 (saturated); without the macro -> all counters read 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with one skid entry and optional performance counters.
// Counters are built only when PIPE_STAGE_PERF_EN is defined; otherwise they read zero.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 36,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  xfer_cnt
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic up_xfer_c;
    logic dn_xfer_c;
    logic main_load_c;

    assign up_xfer_c   = up_valid & ~skid_valid;
    assign dn_xfer_c   = main_valid & dn_ready;
    assign main_load_c = ~main_valid | dn_xfer_c;

    // up_ready comes straight from the skid flop, so dn_ready never reaches it combinationally.
    assign up_ready = ~skid_valid;
    assign dn_valid = main_valid;
    assign ctrl_out = main_ctrl;
    assign data_out = main_data;

    // Main/skid entries; ctrl is zeroed whenever main goes empty so idle output reads as a bubble.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
        end else begin
            if (main_load_c) begin
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    main_ctrl  <= skid_ctrl;
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end else if (up_xfer_c) begin
                    main_valid <= 1'b1;
                    main_ctrl  <= ctrl_in;
                    main_data  <= data_in;
                end else begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                end
            end else if (up_xfer_c) begin
                skid_valid <= 1'b1;
                skid_ctrl  <= ctrl_in;
                skid_data  <= data_in;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] xfer_q;

    // Saturating event counters.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_q <= '0;
            flush_q <= '0;
            xfer_q  <= '0;
        end else begin
            if (main_valid && !dn_ready && stall_q != CNT_MAX)
                stall_q <= stall_q + CNT_W'(1);
            if (flush && (main_valid || skid_valid) && flush_q != CNT_MAX)
                flush_q <= flush_q + CNT_W'(1);
            if (!flush && dn_xfer_c && xfer_q != CNT_MAX)
                xfer_q <= xfer_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
    assign xfer_cnt  = xfer_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign xfer_cnt  = '0;
`endif

endmodule
